// File: rtl/fifo_flow.sv
// Synchronous valid/ready FIFO with occupancy count, almost-full/empty flags,
// synchronous flush and an optional registered output stage.
module fifo_flow #(
    parameter int WIDTH      = 32,
    parameter int DEPTH_LOG2 = 3,
    parameter int OUT_REG    = 0,
    parameter int AFULL_LVL  = 1 << DEPTH_LOG2,
    parameter int AEMPTY_LVL = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIDTH-1:0]      out_data,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  almost_full,
    output logic                  almost_empty
);
    localparam int MEM = 1 << DEPTH_LOG2;
    localparam int CAP = MEM + OUT_REG;
    localparam int PW  = DEPTH_LOG2 + 1;
    localparam logic [DEPTH_LOG2:0] CAP_C    = PW'(CAP);
    localparam logic [DEPTH_LOG2:0] AFULL_C  = PW'(AFULL_LVL);
    localparam logic [DEPTH_LOG2:0] AEMPTY_C = PW'(AEMPTY_LVL);

    if (DEPTH_LOG2 < 1) begin : g_bad_depth
        $error("fifo_flow: DEPTH_LOG2 must be >= 1");
    end
    if (OUT_REG != 0 && OUT_REG != 1) begin : g_bad_outreg
        $error("fifo_flow: OUT_REG must be 0 or 1");
    end
    if (AFULL_LVL < 1 || AFULL_LVL > CAP) begin : g_bad_afull
        $error("fifo_flow: AFULL_LVL out of range 1..CAP");
    end
    if (AEMPTY_LVL < 0 || AEMPTY_LVL > CAP - 1) begin : g_bad_aempty
        $error("fifo_flow: AEMPTY_LVL out of range 0..CAP-1");
    end

    logic [WIDTH-1:0]    mem_q [MEM];
    logic [DEPTH_LOG2:0] head_q, head_d, tail_q, tail_d, count_q, count_d;
    logic                full, mem_empty, push, pop, head_adv;

    assign mem_empty    = (head_q == tail_q);
    assign full         = (count_q == CAP_C);
    assign in_ready     = !full && !flush;
    assign push         = in_valid && in_ready;
    assign pop          = out_valid && out_ready && !flush;
    assign count        = count_q;
    assign almost_full  = (count_q >= AFULL_C);
    assign almost_empty = (count_q <= AEMPTY_C);

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (push)     tail_d = tail_q + PW'(1);
            if (head_adv) head_d = head_q + PW'(1);
            if (push && !pop)      count_d = count_q + PW'(1);
            else if (pop && !push) count_d = count_q - PW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Storage needs no reset: nothing reads an entry before it is written.
    always_ff @(posedge clk) begin
        if (push) mem_q[tail_q[DEPTH_LOG2-1:0]] <= in_data;
    end

    if (OUT_REG == 1) begin : g_out_reg
        logic             out_vld_q, out_vld_d, load;
        logic [WIDTH-1:0] out_data_q, out_data_d;

        // Refill the output stage whenever it is empty or being drained this cycle.
        always_comb begin
            load       = (!out_vld_q || pop) && !mem_empty && !flush;
            out_vld_d  = out_vld_q;
            out_data_d = out_data_q;
            if (flush) begin
                out_vld_d = 1'b0;
            end else if (load) begin
                out_vld_d  = 1'b1;
                out_data_d = mem_q[head_q[DEPTH_LOG2-1:0]];
            end else if (pop) begin
                out_vld_d = 1'b0;
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                out_vld_q  <= 1'b0;
                out_data_q <= '0;
            end else begin
                out_vld_q  <= out_vld_d;
                out_data_q <= out_data_d;
            end
        end

        assign head_adv  = load;
        assign out_valid = out_vld_q;
        assign out_data  = out_data_q;
    end else begin : g_out_comb
        assign head_adv  = pop;
        assign out_valid = !mem_empty;
        assign out_data  = mem_q[head_q[DEPTH_LOG2-1:0]];
    end
endmodule

// File: tb/tb_fifo_flow.sv
// Directed bench for fifo_flow: one combinational-output instance with custom
// flag levels and one registered-output instance with default levels.
module tb_fifo_flow;
    logic clk, rst;

    logic        flush0, iv0, ir0, ov0, or0, af0, ae0;
    logic [31:0] id0, od0;
    logic [3:0]  cnt0;

    logic        flush1, iv1, ir1, ov1, or1, af1, ae1;
    logic [31:0] id1, od1;
    logic [3:0]  cnt1;

    int checks = 0;
    int errors = 0;
    logic [31:0] q[$];

    fifo_flow #(.WIDTH(32), .DEPTH_LOG2(3), .OUT_REG(0), .AFULL_LVL(6), .AEMPTY_LVL(2)) u0 (
        .clk(clk), .rst(rst), .flush(flush0),
        .in_valid(iv0), .in_ready(ir0), .in_data(id0),
        .out_valid(ov0), .out_ready(or0), .out_data(od0),
        .count(cnt0), .almost_full(af0), .almost_empty(ae0)
    );

    fifo_flow #(.WIDTH(32), .DEPTH_LOG2(3), .OUT_REG(1)) u1 (
        .clk(clk), .rst(rst), .flush(flush1),
        .in_valid(iv1), .in_ready(ir1), .in_data(id1),
        .out_valid(ov1), .out_ready(or1), .out_data(od1),
        .count(cnt1), .almost_full(af1), .almost_empty(ae1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1;
        flush0 = 0; iv0 = 0; or0 = 0; id0 = 0;
        flush1 = 0; iv1 = 0; or1 = 0; id1 = 0;
        tick();
        tick();
        chk("rst_cnt0", 32'(cnt0), 0);
        chk("rst_ov0", 32'(ov0), 0);
        chk("rst_ir0", 32'(ir0), 1);
        chk("rst_af0", 32'(af0), 0);
        chk("rst_ae0", 32'(ae0), 1);
        chk("rst_od1", od1, 0);
        chk("rst_ov1", 32'(ov1), 0);
        rst = 1'b0;

        // Three pushes, then drain in order
        iv0 = 1; id0 = 32'hA1;
        tick();
        chk("p1_cnt", 32'(cnt0), 1);
        chk("p1_ov", 32'(ov0), 1);
        chk("p1_od", od0, 32'hA1);
        id0 = 32'hA2;
        tick();
        chk("p2_cnt", 32'(cnt0), 2);
        id0 = 32'hA3;
        tick();
        chk("p3_cnt", 32'(cnt0), 3);
        chk("p3_ae", 32'(ae0), 0);
        iv0 = 0; or0 = 1;
        chk("pop_a1", od0, 32'hA1);
        tick();
        chk("pop_a2", od0, 32'hA2);
        chk("pop_cnt2", 32'(cnt0), 2);
        tick();
        chk("pop_a3", od0, 32'hA3);
        tick();
        chk("drain_cnt", 32'(cnt0), 0);
        chk("drain_ov", 32'(ov0), 0);
        or0 = 0;

        // Fill to capacity, walking the flag thresholds
        iv0 = 1;
        for (int i = 0; i < 8; i++) begin
            id0 = 32'h10 + 32'(i);
            q.push_back(id0);
            tick();
            chk("fill_cnt", 32'(cnt0), 32'(i + 1));
            chk("fill_af", 32'(af0), (i + 1 >= 6) ? 1 : 0);
            chk("fill_ae", 32'(ae0), (i + 1 <= 2) ? 1 : 0);
        end
        chk("full_ir", 32'(ir0), 0);
        id0 = 32'h99;
        tick();
        tick();
        chk("held_cnt", 32'(cnt0), 8);
        chk("held_ir", 32'(ir0), 0);
        or0 = 1;
        chk("full_pop_od", od0, q[0]);
        tick();
        void'(q.pop_front());
        chk("full_pop_cnt", 32'(cnt0), 7);
        chk("full_pop_ir", 32'(ir0), 1);
        or0 = 0;
        tick();
        q.push_back(32'h99);
        chk("ninth_cnt", 32'(cnt0), 8);
        iv0 = 0; or0 = 1;
        while (q.size() > 0) begin
            chk("drain_od", od0, q[0]);
            tick();
            void'(q.pop_front());
        end
        or0 = 0;
        chk("empty_cnt", 32'(cnt0), 0);
        chk("empty_ov", 32'(ov0), 0);

        // Streaming at count 4 across many pointer wraps
        iv0 = 1;
        for (int i = 0; i < 4; i++) begin
            id0 = 32'h20 + 32'(i);
            q.push_back(id0);
            tick();
        end
        or0 = 1;
        for (int k = 0; k < 100; k++) begin
            id0 = 32'h1000 + 32'(k);
            chk("stream_od", od0, q[0]);
            tick();
            q.push_back(id0);
            void'(q.pop_front());
            chk("stream_cnt", 32'(cnt0), 4);
        end
        or0 = 0;
        id0 = 32'h5;
        tick();
        iv0 = 0;
        chk("pre_flush_cnt", 32'(cnt0), 5);

        // Flush with concurrent push and pop
        flush0 = 1; iv0 = 1; or0 = 1; id0 = 32'hEE;
        #1;
        chk("flush_ir", 32'(ir0), 0);
        tick();
        flush0 = 0; iv0 = 0; or0 = 0;
        q.delete();
        chk("flush_cnt", 32'(cnt0), 0);
        chk("flush_ov", 32'(ov0), 0);
        chk("flush_ae", 32'(ae0), 1);
        iv0 = 1; id0 = 32'h77;
        tick();
        iv0 = 0;
        chk("post_flush_od", od0, 32'h77);
        chk("post_flush_cnt", 32'(cnt0), 1);

        // Asynchronous reset in the middle of a burst
        iv0 = 1; id0 = 32'h88;
        tick();
        tick();
        chk("burst_cnt", 32'(cnt0), 3);
        #2;
        rst = 1;
        #1;
        chk("arst_cnt", 32'(cnt0), 0);
        chk("arst_ov", 32'(ov0), 0);
        chk("arst_ir", 32'(ir0), 1);
        chk("arst_af", 32'(af0), 0);
        chk("arst_ae", 32'(ae0), 1);
        iv0 = 0;
        tick();
        rst = 0;

        // Registered output: two-cycle latency and capacity of 9
        iv1 = 1; id1 = 32'h55;
        tick();
        iv1 = 0;
        chk("r_n1_ov", 32'(ov1), 0);
        chk("r_n1_cnt", 32'(cnt1), 1);
        tick();
        chk("r_n2_ov", 32'(ov1), 1);
        chk("r_n2_od", od1, 32'h55);
        q.push_back(32'h55);
        iv1 = 1;
        for (int i = 0; i < 8; i++) begin
            id1 = 32'h60 + 32'(i);
            q.push_back(id1);
            tick();
            chk("r_fill_cnt", 32'(cnt1), 32'(i + 2));
        end
        iv1 = 0;
        chk("r_full_ir", 32'(ir1), 0);
        chk("r_full_af", 32'(af1), 1);
        chk("r_full_cnt", 32'(cnt1), 9);
        or1 = 1;
        for (int i = 0; i < 9; i++) begin
            chk("r_pop_ov", 32'(ov1), 1);
            chk("r_pop_od", od1, q[0]);
            tick();
            void'(q.pop_front());
            chk("r_pop_cnt", 32'(cnt1), 32'(8 - i));
        end
        or1 = 0;
        chk("r_empty_ov", 32'(ov1), 0);
        chk("r_empty_ae", 32'(ae1), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
